// File: rtl/cpu_pkg.sv
// Shared CPU definitions: the multi-cycle operation state encoding and default datapath width,
// common to the mult, div and ALU blocks.
package cpu_pkg;

  localparam int unsigned DefaultWidth = 32;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } op_state_e;

endpackage

// File: rtl/mult_abs.sv
// Conditional two's-complement negate: val_o = neg_i ? -val_i : val_i.
module mult_abs #(
  parameter int unsigned Width = 32
) (
  input  logic [Width-1:0] val_i,
  input  logic             neg_i,
  output logic [Width-1:0] val_o
);

  always_comb begin
    val_o = neg_i ? (~val_i + Width'(1)) : val_i;
  end

endmodule

// File: rtl/mult.sv
// Sequential signed multiplier: sign/magnitude shift-add, one multiplier bit per cycle,
// result {hi,lo} registered on the final iteration.
module mult
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             multCtrl,
  output logic             multBusy,
  output logic             multDone,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  op_state_e state_q, state_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               sign_q, sign_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] acc_sum, res;

  // The most-negative operand negates to itself, which read unsigned is the correct magnitude.
  mult_abs #(.Width(WIDTH)) u_abs_a (
    .val_i (srcA),
    .neg_i (srcA[WIDTH-1]),
    .val_o (a_mag)
  );

  mult_abs #(.Width(WIDTH)) u_abs_b (
    .val_i (srcB),
    .neg_i (srcB[WIDTH-1]),
    .val_o (b_mag)
  );

  mult_abs #(.Width(2 * WIDTH)) u_abs_res (
    .val_i (acc_sum),
    .neg_i (sign_q),
    .val_o (res)
  );

  always_comb begin
    acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    sign_d   = sign_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (multCtrl) begin
          mcand_d  = {{WIDTH{1'b0}}, a_mag};
          mplier_d = b_mag;
          sign_d   = srcA[WIDTH-1] ^ srcB[WIDTH-1];
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = StRun;
        end else if (state_q == StDone) begin
          state_d = StIdle;
        end
      end
      StRun: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          {hi_d, lo_d} = res;
          state_d      = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      sign_q   <= sign_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign multBusy = (state_q == StRun);
  assign multDone = (state_q == StDone);
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mult.sv
// Directed plus random checks of mult against a plain signed-arithmetic product model.
module tb_mult;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] srcA, srcB;
  logic         multCtrl;
  logic         multBusy, multDone;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int errors = 0;

  mult #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .srcA     (srcA),
    .srcB     (srcB),
    .multCtrl (multCtrl),
    .multBusy (multBusy),
    .multDone (multDone),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a b, then checks busy/done timing, hi/lo hold during the run, and the result.
  // Leaves the bench one settle after the completion edge (DUT in DONE).
  // glitch_at >= 0 re-pulses multCtrl with 2 x 2 for one cycle at that point in the run.
  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int glitch_at);
    logic [63:0] held;
    int prof_bad;
    int hold_bad;
    held     = {hi, lo};
    prof_bad = 0;
    hold_bad = 0;
    srcA     = a;
    srcB     = b;
    multCtrl = 1'b1;
    tick();
    multCtrl = 1'b0;
    for (int i = 0; i < W; i++) begin
      srcA = $urandom;
      srcB = $urandom;
      if (i == glitch_at) begin
        multCtrl = 1'b1;
        srcA     = 32'd2;
        srcB     = 32'd2;
      end
      if (multBusy !== 1'b1 || multDone !== 1'b0) prof_bad++;
      if ({hi, lo} !== held) hold_bad++;
      tick();
      multCtrl = 1'b0;
    end
    check({tag, " busy profile"}, 64'(prof_bad), 64'd0);
    check({tag, " hold during run"}, 64'(hold_bad), 64'd0);
    check({tag, " done"}, {62'd0, multDone, multBusy}, 64'b10);
    check({tag, " product"}, {hi, lo}, ref_prod(a, b));
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [63:0]  res;
    int           bad;

    reset    = 1'b1;
    srcA     = '0;
    srcB     = '0;
    multCtrl = 1'b0;
    #2;
    check("reset outputs", {hi, lo}, 64'd0);
    check("reset flags", {62'd0, multBusy, multDone}, 64'd0);
    tick();
    tick();
    #3;
    reset = 1'b0;
    tick();
    check("idle flags", {62'd0, multBusy, multDone}, 64'd0);

    do_op("3x5", 32'd3, 32'd5, -1);
    check("3x5 literal", {hi, lo}, 64'h0000_0000_0000_000F);
    tick();
    check("done one cycle", {62'd0, multBusy, multDone}, 64'd0);
    check("hold after done", {hi, lo}, 64'h0000_0000_0000_000F);

    do_op("-7x6", 32'hFFFF_FFF9, 32'h0000_0006, -1);
    check("-7x6 literal", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFD6);
    // Back-to-back starts from the DONE cycle.
    do_op("minxmin", 32'h8000_0000, 32'h8000_0000, -1);
    check("minxmin literal", {hi, lo}, 64'h4000_0000_0000_0000);
    do_op("m1xmax", 32'hFFFF_FFFF, 32'h7FFF_FFFF, -1);
    check("m1xmax literal", {hi, lo}, 64'hFFFF_FFFF_8000_0001);
    do_op("0xmin", 32'h0, 32'h8000_0000, -1);
    do_op("m1x0", 32'hFFFF_FFFF, 32'h0, -1);
    tick();

    do_op("100x100 glitch", 32'd100, 32'd100, 10);
    check("100x100 literal", {hi, lo}, 64'h0000_0000_0000_2710);
    do_op("2x2 from done", 32'd2, 32'd2, -1);
    check("2x2 literal", {hi, lo}, 64'd4);
    tick();

    // Reset mid-period partway through a run.
    srcA     = 32'hFFFF;
    srcB     = 32'hFFFF;
    multCtrl = 1'b1;
    tick();
    multCtrl = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    #3;
    reset = 1'b1;
    #1;
    check("abort outputs", {hi, lo}, 64'd0);
    check("abort flags", {62'd0, multBusy, multDone}, 64'd0);
    tick();
    #3;
    reset = 1'b0;
    bad   = 0;
    for (int i = 0; i < W + 8; i++) begin
      tick();
      if (multDone !== 1'b0 || multBusy !== 1'b0) bad++;
    end
    check("no done after abort", 64'(bad), 64'd0);
    do_op("0xm1 after reset", 32'h0, 32'hFFFF_FFFF, -1);
    check("0xm1 literal", {hi, lo}, 64'd0);

    for (int n = 0; n < 16; n++) begin
      ra = $urandom;
      rb = $urandom;
      if (n % 4 == 1) ra = 32'h8000_0000;
      if (n % 4 == 2) rb = $urandom_range(0, 15);
      if (n % 4 == 3) ra = -$urandom_range(1, 15);
      do_op("random", ra, rb, (n % 3 == 0) ? int'($urandom_range(0, W - 2)) : -1);
      if (n % 2 == 0) begin
        res = {hi, lo};
        tick();
        tick();
        check("random idle hold", {hi, lo}, res);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

endmodule
